// File: rtl/mycore_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mycore_pkg : shared types for the ioctl-to-SDRAM loader path
// Rev 1.0
// ----------------------------------------------------------------------------
package mycore_pkg;

    localparam int DEF_ADDR_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [15:0]           data;
    } ram_wr_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo2 : two-entry register FIFO of ram_wr_t, head and count registered
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo2
    import mycore_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  ram_wr_t     din_i,
    output ram_wr_t     head_o,
    output logic [1:0]  count_o
);

    ram_wr_t    slot0_q;
    ram_wr_t    slot1_q;
    logic [1:0] count_q;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = pop_i && (count_q != 2'd0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push = push_i && ((count_q != 2'd2) || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= din_i;
                    else                 slot1_q <= din_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_q <= din_i;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ioctl_sdram_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ioctl_sdram_loader : buffers HPS ioctl words and writes them to SDRAM
// Rev 1.0
// ----------------------------------------------------------------------------
module ioctl_sdram_loader
    import mycore_pkg::*;
#(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [7:0]        INDEX  = 8'h00,
    parameter logic              SWAP   = 1'b0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic              ram_ack,
    output logic              rom_ready,
    output logic              overrun,
    output logic [23:0]       words_written
);

    localparam int PKG_AW = DEF_ADDR_W;

    loader_state_t     state_q;
    logic              wait_q;
    logic              rom_ready_q;
    logic              overrun_q;
    logic [23:0]       words_q;

    logic              w_match;
    logic              w_wr_load;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [1:0]        w_count_d;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_data;
    ram_wr_t           w_din;
    ram_wr_t           w_head;
    logic              w_unused_addr0;

    assign w_unused_addr0 = ioctl_addr[0];

    assign w_match   = (ioctl_index == INDEX);
    assign w_wr_load = (state_q == ST_LOAD) && ioctl_wr && w_match;
    assign w_push    = w_wr_load && !wait_q;
    assign w_pop     = ram_ack && (w_count != 2'd0);
    assign w_count_d = w_count + {1'b0, w_push} - {1'b0, w_pop};

    // Word-align the host address, then offset; the sum wraps at ADDR_W bits.
    assign w_addr     = BASE + {ioctl_addr[ADDR_W-1:1], 1'b0};
    assign w_data     = SWAP ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
    assign w_din.addr = PKG_AW'(w_addr);
    assign w_din.data = w_data;

    sync_fifo2 u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .head_o  (w_head),
        .count_o (w_count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= 1'b0;
            rom_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
            words_q     <= 24'd0;
        end else begin
            wait_q <= (w_count_d == 2'd2);
            if (w_wr_load && wait_q) overrun_q <= 1'b1;
            if (w_pop && (words_q != 24'hFFFFFF)) words_q <= words_q + 24'd1;
            case (state_q)
                ST_IDLE: begin
                    if (ioctl_download && w_match) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!ioctl_download) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // A registered empty count means the last ack has already retired.
                    if (w_count == 2'd0) begin
                        state_q     <= ST_DONE;
                        rom_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ioctl_download && w_match) begin
                        state_q     <= ST_LOAD;
                        rom_ready_q <= 1'b0;
                        words_q     <= 24'd0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ioctl_wait    = wait_q;
    assign ram_req       = (w_count != 2'd0);
    assign ram_addr      = ADDR_W'(w_head.addr);
    assign ram_wdata     = w_head.data;
    assign rom_ready     = rom_ready_q;
    assign overrun       = overrun_q;
    assign words_written = words_q;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_sdram_loader.sv
`default_nettype none
// Bench for ioctl_sdram_loader: two instances (swap / wrapped base) against a queue model.
module tb_ioctl_sdram_loader;

    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3;
    localparam logic [24:0] BASE0 = 25'h0;
    localparam logic [24:0] BASE1 = 25'h1FFFFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        download = 1'b0;
    logic [7:0]  idx = 8'h00;
    logic        wr = 1'b0;
    logic [24:0] addr = '0;
    logic [15:0] dout = '0;
    logic        ram_ack = 1'b0;
    logic        ack_en = 1'b0;
    logic        ack_force = 1'b0;
    logic        started = 1'b0;

    logic        wait0, req0, rom0, ovr0;
    logic [24:0] addr0;
    logic [15:0] wd0;
    logic [23:0] ww0;
    logic        wait1, req1, rom1, ovr1;
    logic [24:0] addr1;
    logic [15:0] wd1;
    logic [23:0] ww1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ioctl_sdram_loader #(.ADDR_W(25), .BASE(BASE0), .INDEX(8'h00), .SWAP(1'b1)) dut0 (
        .clk_sys(clk), .reset(reset), .ioctl_download(download), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait0),
        .ram_req(req0), .ram_addr(addr0), .ram_wdata(wd0), .ram_ack(ram_ack),
        .rom_ready(rom0), .overrun(ovr0), .words_written(ww0));

    ioctl_sdram_loader #(.ADDR_W(25), .BASE(BASE1), .INDEX(8'h00), .SWAP(1'b0)) dut1 (
        .clk_sys(clk), .reset(reset), .ioctl_download(download), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait1),
        .ram_req(req1), .ram_addr(addr1), .ram_wdata(wd1), .ram_ack(ram_ack),
        .rom_ready(rom1), .overrun(ovr1), .words_written(ww1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    function automatic logic [24:0] exp_addr(input logic [24:0] base, input logic [24:0] a);
        logic [24:0] aligned;
        aligned = {a[24:1], 1'b0};
        return base + aligned;
    endfunction

    function automatic logic [15:0] bswap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic [24:0] a; logic [15:0] d; } raw_t;
    raw_t mq[$];
    int   m_mode = M_IDLE;
    bit   m_wait = 0, m_ready = 0, m_ovr = 0;
    int   m_words = 0;
    int   m_sz0;
    bit   m_strobe;
    raw_t m_ent;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_mode = M_IDLE; m_wait = 0; m_ready = 0; m_ovr = 0; m_words = 0;
        end else begin
            m_sz0    = mq.size();
            m_strobe = (m_mode == M_LOAD) && wr && (idx == 8'h00);
            if (ram_ack && m_sz0 > 0) begin
                void'(mq.pop_front());
                if (m_words < 24'hFFFFFF) m_words++;
            end
            if (m_strobe && m_wait) m_ovr = 1;
            else if (m_strobe) begin
                m_ent.a = addr; m_ent.d = dout;
                mq.push_back(m_ent);
            end
            m_wait = (mq.size() == 2);
            case (m_mode)
                M_IDLE:  if (download && idx == 8'h00) m_mode = M_LOAD;
                M_LOAD:  if (!download) m_mode = M_DRAIN;
                M_DRAIN: if (m_sz0 == 0) begin m_mode = M_DONE; m_ready = 1; end
                default: if (download && idx == 8'h00) begin
                    m_mode = M_LOAD; m_ready = 0; m_words = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("wait0", {31'd0, wait0}, {31'd0, m_wait});
            chk("wait1", {31'd0, wait1}, {31'd0, m_wait});
            chk("req0", {31'd0, req0}, {31'd0, mq.size() > 0});
            chk("req1", {31'd0, req1}, {31'd0, mq.size() > 0});
            chk("rom0", {31'd0, rom0}, {31'd0, m_ready});
            chk("rom1", {31'd0, rom1}, {31'd0, m_ready});
            chk("ovr0", {31'd0, ovr0}, {31'd0, m_ovr});
            chk("ovr1", {31'd0, ovr1}, {31'd0, m_ovr});
            chk("words0", {8'd0, ww0}, m_words);
            chk("words1", {8'd0, ww1}, m_words);
            if (mq.size() > 0) begin
                chk("addr0", {7'd0, addr0}, {7'd0, exp_addr(BASE0, mq[0].a)});
                chk("data0", {16'd0, wd0}, {16'd0, bswap(mq[0].d)});
                chk("addr1", {7'd0, addr1}, {7'd0, exp_addr(BASE1, mq[0].a)});
                chk("data1", {16'd0, wd1}, {16'd0, mq[0].d});
            end
        end
    end

    // ---------------- SDRAM side: ack driver and written-memory capture ----------------
    logic [15:0] sd0 [int];
    logic [15:0] sd1 [int];
    logic        pend_v = 1'b0;
    logic [24:0] pa0, pa1;
    logic [15:0] pd0, pd1;

    always begin
        @(negedge clk);
        #1;
        ram_ack = (ack_en && req0) || ack_force;
        pend_v  = ram_ack && req0;
        pa0 = addr0; pd0 = wd0; pa1 = addr1; pd1 = wd1;
    end

    always @(posedge clk) begin
        if (pend_v && !reset) begin
            sd0[int'(pa0)] = pd0;
            sd1[int'(pa1)] = pd1;
        end
    end

    // ---------------- host tasks ----------------
    task automatic send(input logic [24:0] a, input logic [15:0] d);
        int n = 0;
        while (wait0 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) chk("send_wait_timeout", 32'd1, 32'd0);
        wr = 1'b1; addr = a; dout = d;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rom();
        int n = 0;
        while (!rom0 && n < 100) begin @(negedge clk); n++; end
        chk("rom_ready_rise", {31'd0, rom0}, 32'd1);
    endtask

    task automatic reset_vals(input string nm);
        chk({nm, "_req"},   {31'd0, req0}, 32'd0);
        chk({nm, "_wait"},  {31'd0, wait0}, 32'd0);
        chk({nm, "_rom"},   {31'd0, rom0}, 32'd0);
        chk({nm, "_ovr"},   {31'd0, ovr0}, 32'd0);
        chk({nm, "_words"}, {8'd0, ww0}, 32'd0);
        chk({nm, "_addr"},  {7'd0, addr0}, 32'd0);
        chk({nm, "_wdata"}, {16'd0, wd0}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_vals("reset");
        started = 1'b1;
        reset = 1'b0;
        @(negedge clk);

        // ack with no request outstanding is ignored
        ack_force = 1'b1; @(negedge clk); ack_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ack_words", {8'd0, ww0}, 32'd0);

        // foreign index: nothing happens
        idx = 8'h01; download = 1'b1; @(negedge clk);
        send(25'd0, 16'hAAAA);
        send(25'd2, 16'hBBBB);
        download = 1'b0; idx = 8'h00;
        repeat (4) @(negedge clk);
        chk("idx1_rom", {31'd0, rom0}, 32'd0);
        chk("idx1_req", {31'd0, req0}, 32'd0);

        // 8-word load, swapped data
        sd0.delete(); sd1.delete();
        ack_en = 1'b1; download = 1'b1; @(negedge clk);
        for (int i = 0; i < 8; i++) send(25'(2 * i), 16'h1234);
        download = 1'b0;
        wait_rom();
        chk("load8_words", {8'd0, ww0}, 32'd8);
        for (int i = 0; i < 8; i++)
            chk("load8_sdram", sd0.exists(2 * i) ? {16'd0, sd0[2 * i]} : 32'hFFFFFFFF, 32'h3412);

        // stall, back-pressure, overrun
        sd0.delete(); sd1.delete();
        ack_en = 1'b0; download = 1'b1; @(negedge clk);
        send(25'h20, 16'h0001);
        send(25'h22, 16'h0002);
        chk("stall_wait", {31'd0, wait0}, 32'd1);
        chk("stall_no_ovr", {31'd0, ovr0}, 32'd0);
        wr = 1'b1; addr = 25'h100; dout = 16'hDEAD; @(negedge clk);
        wr = 1'b0; @(negedge clk);
        chk("ovr_set", {31'd0, ovr0}, 32'd1);
        chk("ovr_wait_held", {31'd0, wait0}, 32'd1);
        chk("ovr_head", {7'd0, addr0}, 32'h20);
        fork
            begin
                for (int i = 0; i < 4; i++) send(25'(32'h24 + 2 * i), 16'(32'h10 + i));
            end
            begin
                repeat (16) @(negedge clk);
                ack_en = 1'b1;
            end
        join
        download = 1'b0;
        wait_rom();
        chk("stall_words", {8'd0, ww0}, 32'd6);
        chk("stall_sdram_cnt", sd0.num(), 32'd6);
        chk("dropped_absent", {31'd0, sd0.exists(32'h100)}, 32'd0);
        chk("stall_sdram_last", sd0.exists(32'h2A) ? {16'd0, sd0[32'h2A]} : 32'hFFFFFFFF, 32'h1300);

        // reset in the middle of a request
        ack_en = 1'b0; download = 1'b1; @(negedge clk);
        send(25'h40, 16'h5555);
        chk("mid_req", {31'd0, req0}, 32'd1);
        reset = 1'b1; @(negedge clk);
        reset_vals("midreset");
        reset = 1'b0; @(negedge clk);
        ack_en = 1'b1;
        for (int i = 0; i < 3; i++) send(25'(32'h60 + 2 * i), 16'hA5A5);
        download = 1'b0;
        wait_rom();
        chk("reload_words", {8'd0, ww0}, 32'd3);

        // address formatting: wrap on dut1, odd address on dut0
        ack_en = 1'b0; download = 1'b1; @(negedge clk);
        send(25'd4, 16'hBEEF);
        chk("addr4_base0", {7'd0, addr0}, 32'h4);
        chk("addr4_wrap", {7'd0, addr1}, 32'h2);
        chk("data_swap", {16'd0, wd0}, 32'hEFBE);
        chk("data_noswap", {16'd0, wd1}, 32'hBEEF);
        ack_en = 1'b1; repeat (3) @(negedge clk);
        ack_en = 1'b0;
        send(25'd5, 16'h0102);
        chk("addr5_base0", {7'd0, addr0}, 32'h4);
        chk("addr5_wrap", {7'd0, addr1}, 32'h2);
        chk("addr5_data", {16'd0, wd0}, 32'h0201);
        ack_en = 1'b1;
        download = 1'b0;
        wait_rom();
        chk("fmt_words", {8'd0, ww0}, 32'd2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
